press_classifier: RTL and testbench

//  Downstream stage of the switch debouncer: consumes its debounced level and

---
 rtl/press_classifier_if.sv | 28 ++
 rtl/press_classifier.sv | 125 ++++++++++++
 tb/tb_press_classifier.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/press_classifier_if.sv
// Bundle between the debouncer and the press classifier: the debounced level in,
// and the registered press-state level and event ticks out.
interface press_classifier_if;
    logic db_level;
    logic pressed;
    logic press_tick;
    logic short_tick;
    logic long_tick;
    logic rep_tick;

    modport master (
        output db_level,
        input  pressed,
        input  press_tick,
        input  short_tick,
        input  long_tick,
        input  rep_tick
    );

    modport slave (
        input  db_level,
        output pressed,
        output press_tick,
        output short_tick,
        output long_tick,
        output rep_tick
    );
endinterface

// File: rtl/press_classifier.sv
// Classifies debounced presses as short or long and emits one-cycle event ticks.
// Define AUTO_REPEAT_EN to get periodic rep_tick pulses while a long press is held.
module press_classifier #(
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned LONG_CYC = 8,
    parameter int unsigned REP_CYC  = 4
) (
    input logic             clk,
    input logic             reset,
    press_classifier_if.slave bus
);

    if (LONG_CYC < 2 || LONG_CYC > (2 ** CNT_W) - 1) begin : g_bad_long
        $error("LONG_CYC out of range for CNT_W");
    end
    if (REP_CYC < 1 || REP_CYC > (2 ** CNT_W) - 1) begin : g_bad_rep
        $error("REP_CYC out of range for CNT_W");
    end

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHeld = 2'd1,
        StLong = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pressed_q;
    logic             press_tick_q;
    logic             short_tick_q;
    logic             long_tick_q;
`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RepLast = CNT_W'(REP_CYC - 1);
    logic             rep_tick_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            pressed_q    <= 1'b0;
            press_tick_q <= 1'b0;
            short_tick_q <= 1'b0;
            long_tick_q  <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rep_tick_q   <= 1'b0;
`endif
        end else begin
            press_tick_q <= 1'b0;
            short_tick_q <= 1'b0;
            long_tick_q  <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rep_tick_q   <= 1'b0;
`endif
            case (state_q)
                StIdle: begin
                    if (bus.db_level) begin
                        state_q      <= StHeld;
                        cnt_q        <= CntOne;
                        pressed_q    <= 1'b1;
                        press_tick_q <= 1'b1;
                    end else begin
                        cnt_q     <= '0;
                        pressed_q <= 1'b0;
                    end
                end
                StHeld: begin
                    if (!bus.db_level) begin
                        // A low sample always exits here first, so short and long never collide.
                        state_q      <= StIdle;
                        cnt_q        <= '0;
                        pressed_q    <= 1'b0;
                        short_tick_q <= 1'b1;
                    end else if (cnt_q == LongLast) begin
                        state_q     <= StLong;
                        cnt_q       <= '0;
                        pressed_q   <= 1'b1;
                        long_tick_q <= 1'b1;
                    end else begin
                        cnt_q     <= cnt_q + CntOne;
                        pressed_q <= 1'b1;
                    end
                end
                StLong: begin
                    if (!bus.db_level) begin
                        state_q   <= StIdle;
                        cnt_q     <= '0;
                        pressed_q <= 1'b0;
                    end else begin
                        pressed_q <= 1'b1;
`ifdef AUTO_REPEAT_EN
                        if (cnt_q == RepLast) begin
                            cnt_q      <= '0;
                            rep_tick_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CntOne;
                        end
`else
                        cnt_q <= '0;
`endif
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    cnt_q     <= '0;
                    pressed_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pressed    = pressed_q;
    assign bus.press_tick = press_tick_q;
    assign bus.short_tick = short_tick_q;
    assign bus.long_tick  = long_tick_q;
`ifdef AUTO_REPEAT_EN
    assign bus.rep_tick   = rep_tick_q;
`else
    assign bus.rep_tick   = 1'b0;
`endif

endmodule

// File: tb/tb_press_classifier.sv
// Directed bench for press_classifier: level patterns in, per-cycle tick maps checked
// against hand-computed vectors (bit i-1 = output after the i-th clock edge of a pattern).
module tb_press_classifier;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    logic [63:0] press_log, short_log, long_log, rep_log, pressed_log;
    int          multi_cnt;

    press_classifier_if bus ();

    press_classifier #(
        .CNT_W   (4),
        .LONG_CYC(8),
        .REP_CYC (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef AUTO_REPEAT_EN
    localparam logic [63:0] RepExp20 = 64'h8_8800;
`else
    localparam logic [63:0] RepExp20 = 64'h0;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {bus.pressed, bus.press_tick, bus.short_tick, bus.long_tick, bus.rep_tick};
    endfunction

    // Drives pat[0..len-1] one bit per edge and logs every output after each edge.
    task automatic run_seq(input logic [63:0] pat, input int len);
        int ticks;
        press_log   = '0;
        short_log   = '0;
        long_log    = '0;
        rep_log     = '0;
        pressed_log = '0;
        multi_cnt   = 0;
        for (int i = 0; i < len; i++) begin
            bus.db_level = pat[i];
            @(posedge clk);
            #1;
            press_log[i]   = bus.press_tick;
            short_log[i]   = bus.short_tick;
            long_log[i]    = bus.long_tick;
            rep_log[i]     = bus.rep_tick;
            pressed_log[i] = bus.pressed;
            ticks = int'(bus.press_tick) + int'(bus.short_tick) + int'(bus.long_tick)
                  + int'(bus.rep_tick);
            if (ticks > 1) multi_cnt++;
        end
    endtask

    task automatic check_seq(input string name, input logic [63:0] e_press,
                             input logic [63:0] e_short, input logic [63:0] e_long,
                             input logic [63:0] e_rep, input logic [63:0] e_pressed);
        check({name, ".press"},   press_log,   e_press);
        check({name, ".short"},   short_log,   e_short);
        check({name, ".long"},    long_log,    e_long);
        check({name, ".rep"},     rep_log,     e_rep);
        check({name, ".pressed"}, pressed_log, e_pressed);
        check({name, ".excl"},    64'(multi_cnt), 64'd0);
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        reset        = 1'b1;
        bus.db_level = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 64'(outs()), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // 3 high samples: short press
        run_seq(64'b00111, 5);
        check_seq("hold3", 64'h1, 64'h8, 64'h0, 64'h0, 64'h7);

        // 7 high: one short of the threshold
        run_seq(64'b00_1111111, 9);
        check_seq("hold7", 64'h1, 64'h80, 64'h0, 64'h0, 64'h7F);

        // 8 high: exactly the threshold, no short on release
        run_seq(64'b00_11111111, 10);
        check_seq("hold8", 64'h1, 64'h0, 64'h80, 64'h0, 64'hFF);

        // 20 high: long at edge 8, repeats at 12/16/20 only with the macro
        run_seq({40'h0, 4'h0, 20'hF_FFFF}, 24);
        check_seq("hold20", 64'h1, 64'h0, 64'h80, RepExp20, 64'hF_FFFF);

        // Two presses separated by a single low sample
        run_seq(64'b001110111, 9);
        check_seq("b2b", 64'h11, 64'h88, 64'h0, 64'h0, 64'h77);

        // Reset asserted mid-press in HELD, level kept high
        run_seq(64'b111, 3);
        check("pre_rst_pressed", pressed_log, 64'h7);
        reset = 1'b1;
        #1;
        check("rst_async", 64'(outs()), 64'h0);
        @(posedge clk);
        #1;
        check("rst_held", 64'(outs()), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_rel_press", 64'(outs()), 64'b11000);
        @(posedge clk);
        #1;
        check("rst_rel_held", 64'(outs()), 64'b10000);
        bus.db_level = 1'b0;
        @(posedge clk);
        #1;
        check("rst_rel_short", 64'(outs()), 64'b00100);
        @(posedge clk);
        #1;
        check("rst_rel_idle", 64'(outs()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
